layer_generator: RTL and testbench

Parametrised pseudo-random map-layer generator for the platform game. On request it emits a configurable number of start-up layers. After that, each request produces one new layer of COLS platform cells plus a block-type mask, formed by up to TRACKS independently wandering tracks. It feeds the map/layer store, which captures `layer_map` and `block_type` on `load_layer`.

---
 rtl/layer_generator.sv | 210 +++++++++++++++++++++
 tb/tb_layer_generator.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_generator.sv
// layer_generator
//   Pseudo-random map-layer generator. A start-up request emits INIT_LAYERS
//   fixed-pattern layers; each later request emits one layer whose
//   block-type mask comes from up to TRACKS wandering one-hot tracks.
//
//   Optional feature macro: LAYER_GEN_SEED_LOAD_EN adds seed_load/seed_in.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   generate_map in   request level, sampled in S_START and S_IDLE
//   seed_load    in   (LAYER_GEN_SEED_LOAD_EN) reseed PRNG, clear secondaries
//   seed_in      in   (LAYER_GEN_SEED_LOAD_EN) 32-bit seed value
//   layer_map    out  platform pattern of current layer (index 0 leftmost)
//   block_type   out  OR of all active track vectors (combinational)
//   load_layer   out  one-cycle strobe, layer outputs valid
//   map_ready    out  one-cycle strobe with the last start-up layer
//   busy         out  high while in S_INIT or S_GENERATE
//
// state      | meaning
// S_START    | after reset, waiting for the first request
// S_INIT     | emitting start-up layers, one per cycle
// S_IDLE     | waiting for a layer request
// S_GENERATE | emitting one generated layer
module layer_generator #(
  parameter int          COLS         = 7,
  parameter int          TRACKS       = 2,
  parameter int          INIT_LAYERS  = 4,
  parameter logic [31:0] SEED         = 32'd987654321,
  parameter logic [3:0]  SPAWN_THRESH = 4'hA
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            generate_map,
`ifdef LAYER_GEN_SEED_LOAD_EN
  input  logic            seed_load,
  input  logic [31:0]     seed_in,
`endif
  output logic [0:COLS-1] layer_map,
  output logic [0:COLS-1] block_type,
  output logic            load_layer,
  output logic            map_ready,
  output logic            busy
);

  localparam int CW = $clog2(INIT_LAYERS);

  function automatic logic [0:COLS-1] alt_pattern();
    logic [0:COLS-1] p;
    for (int i = 0; i < COLS; i++) p[i] = (i % 2 == 0);
    return p;
  endfunction

  localparam logic [0:COLS-1] CENTER = {1'b1, {(COLS-1){1'b0}}} >> (COLS/2);
  localparam logic [0:COLS-1] ALT    = alt_pattern();

  function automatic logic [31:0] taus(input logic [31:0] z, input logic [31:0] m,
                                       input int a, input int b, input int c);
    return ((z & m) << a) ^ (((z << b) ^ z) >> c);
  endfunction

  // Index 0 is the MSB, so moving toward COLS-1 is a right shift.
  // Edges bounce regardless of the direction bit.
  function automatic logic [0:COLS-1] move_track(input logic [0:COLS-1] v, input logic d);
    if (v[0])             return v >> 1;
    else if (v[COLS-1])   return v << 1;
    else if (d)           return v >> 1;
    else                  return v << 1;
  endfunction

  typedef enum logic [1:0] {S_START, S_INIT, S_IDLE, S_GENERATE} state_t;

  state_t          state;
  logic [31:0]     z1, z2, z3, z4;
  logic [31:0]     rnd;
  logic [TRACKS-1:0] dir;
  logic [0:COLS-1] track [TRACKS];
  logic [3:0]      life  [TRACKS];
  logic [CW-1:0]   init_cnt;
  logic            spawned_prev;
  logic [0:COLS-1] trk0_next;
  logic            spawn_en;
  logic [1:0]      spawn_idx;
  logic            unused_rnd;

  assign rnd        = z1 ^ z2 ^ z3 ^ z4;
  assign unused_rnd = ^rnd;
  assign trk0_next  = move_track(track[0], dir[0]);

  always_comb begin
    block_type = '0;
    for (int t = 0; t < TRACKS; t++) block_type = block_type | track[t];
  end

  // Lowest-index secondary track that is inactive at the start of the layer.
  always_comb begin
    spawn_en  = 1'b0;
    spawn_idx = '0;
    for (int t = TRACKS-1; t >= 1; t--) begin
      if (track[t] == '0) begin
        spawn_en  = 1'b1;
        spawn_idx = 2'(t);
      end
    end
    if (spawned_prev || (rnd[3:0] >= SPAWN_THRESH)) spawn_en = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_START;
      z1           <= SEED;
      z2           <= SEED;
      z3           <= SEED;
      z4           <= SEED;
      dir          <= '0;
      init_cnt     <= '0;
      spawned_prev <= 1'b0;
      layer_map    <= '0;
      load_layer   <= 1'b0;
      map_ready    <= 1'b0;
      busy         <= 1'b0;
      for (int t = 0; t < TRACKS; t++) begin
        track[t] <= '0;
        life[t]  <= '0;
      end
    end else begin
      z1 <= taus(z1, 32'hFFFFFFFE, 18, 6, 13);
      z2 <= taus(z2, 32'hFFFFFFF8, 2, 2, 27);
      z3 <= taus(z3, 32'hFFFFFFF0, 7, 13, 21);
      z4 <= taus(z4, 32'hFFFFFF80, 13, 3, 12);
      for (int t = 0; t < TRACKS; t++) dir[t] <= ^rnd[8*t +: 8];
      load_layer <= 1'b0;
      map_ready  <= 1'b0;

      case (state)
        S_START: begin
          if (generate_map) begin
            state    <= S_INIT;
            init_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        S_INIT: begin
          load_layer <= 1'b1;
          if (init_cnt == '0) begin
            layer_map <= CENTER;
            track[0]  <= CENTER;
          end else begin
            layer_map <= (init_cnt == CW'(1)) ? ALT : ~layer_map;
            track[0]  <= trk0_next;
          end
          for (int t = 1; t < TRACKS; t++) begin
            track[t] <= '0;
            life[t]  <= '0;
          end
          if (init_cnt == CW'(INIT_LAYERS - 1)) begin
            map_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            init_cnt <= init_cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (generate_map) begin
            state <= S_GENERATE;
            busy  <= 1'b1;
          end
        end
        S_GENERATE: begin
          layer_map <= ~layer_map;
          track[0]  <= trk0_next;
          for (int t = 1; t < TRACKS; t++) begin
            if (track[t] != '0) begin
              if (life[t] == 4'd0) begin
                track[t] <= '0;
              end else begin
                track[t] <= move_track(track[t], dir[t]);
                life[t]  <= life[t] - 4'd1;
              end
            end else if (spawn_en && (spawn_idx == 2'(t))) begin
              track[t] <= trk0_next;
              life[t]  <= rnd[7:4];
            end
          end
          spawned_prev <= spawn_en;
          load_layer   <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_START;
      endcase

`ifdef LAYER_GEN_SEED_LOAD_EN
      if (seed_load) begin
        z1 <= seed_in;
        z2 <= seed_in;
        z3 <= seed_in;
        z4 <= seed_in;
        spawned_prev <= 1'b0;
        for (int t = 1; t < TRACKS; t++) begin
          track[t] <= '0;
          life[t]  <= '0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_layer_generator.sv
// tb_layer_generator
//   Two instances share clock and request: dut_a with default parameters,
//   dut_b with TRACKS=4 and SPAWN_THRESH=4'hF. A behavioural model of each
//   (track positions as integers, lifetimes as counts) is compared against
//   the outputs on every falling edge. Directed literal checks pin the
//   start-up patterns, reset behaviour and strobe throughput.
`timescale 1ns/1ps
module tb_layer_generator;
  localparam int COLS = 7;
  localparam int INIT = 4;
  localparam int NI   = 2;
  localparam logic [31:0] SEED = 32'd987654321;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gm  = 1'b0;
`ifdef LAYER_GEN_SEED_LOAD_EN
  logic        seed_load = 1'b0;
  logic [31:0] seed_in   = 32'h0;
`endif

  logic [0:COLS-1] lm_a, bt_a, lm_b, bt_b;
  logic ld_a, rd_a, by_a, ld_b, rd_b, by_b;

  always #5 clk = ~clk;

  layer_generator dut_a (
    .clk(clk), .rst(rst), .generate_map(gm),
`ifdef LAYER_GEN_SEED_LOAD_EN
    .seed_load(seed_load), .seed_in(seed_in),
`endif
    .layer_map(lm_a), .block_type(bt_a), .load_layer(ld_a),
    .map_ready(rd_a), .busy(by_a)
  );

  layer_generator #(.TRACKS(4), .SPAWN_THRESH(4'hF)) dut_b (
    .clk(clk), .rst(rst), .generate_map(gm),
`ifdef LAYER_GEN_SEED_LOAD_EN
    .seed_load(seed_load), .seed_in(seed_in),
`endif
    .layer_map(lm_b), .block_type(bt_b), .load_layer(ld_b),
    .map_ready(rd_b), .busy(by_b)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 waiting for first request, 1 start-up, 2 idle, 3 generating
  int              m_mode  [NI];
  int              m_k     [NI];
  logic [0:COLS-1] m_lm    [NI];
  bit              m_load  [NI];
  bit              m_ready [NI];
  bit              m_busy  [NI];
  logic [31:0]     m_z     [NI][4];
  bit              m_dir   [NI][4];
  int              m_pos   [NI][4];
  bit              m_act   [NI][4];
  int              m_life  [NI][4];
  bit              m_sp_prev [NI];
  int              m_tracks [NI] = '{2, 4};
  int              m_thr    [NI] = '{10, 15};
  int              m_spawns  = 0;
  int              m_expires = 0;

  function automatic logic [31:0] tstep(input logic [31:0] z, input int j);
    logic [31:0] m;
    int a, b, c;
    case (j)
      0:       begin m = 32'hFFFFFFFE; a = 18; b = 6;  c = 13; end
      1:       begin m = 32'hFFFFFFF8; a = 2;  b = 2;  c = 27; end
      2:       begin m = 32'hFFFFFFF0; a = 7;  b = 13; c = 21; end
      default: begin m = 32'hFFFFFF80; a = 13; b = 3;  c = 12; end
    endcase
    return ((z & m) << a) ^ (((z << b) ^ z) >> c);
  endfunction

  function automatic int mv(input int p, input bit d);
    if (p == 0)        return 1;
    if (p == COLS - 1) return COLS - 2;
    return d ? p + 1 : p - 1;
  endfunction

  function automatic logic [0:COLS-1] exp_bt(input int i);
    logic [0:COLS-1] v;
    v = '0;
    for (int t = 0; t < m_tracks[i]; t++) if (m_act[i][t]) v[m_pos[i][t]] = 1'b1;
    return v;
  endfunction

  task automatic m_reset(input int i);
    m_mode[i] = 0; m_k[i] = 0; m_lm[i] = '0;
    m_load[i] = 0; m_ready[i] = 0; m_busy[i] = 0; m_sp_prev[i] = 0;
    for (int j = 0; j < 4; j++) begin
      m_z[i][j] = SEED; m_dir[i][j] = 0;
      m_pos[i][j] = 0; m_act[i][j] = 0; m_life[i][j] = 0;
    end
  endtask

  task automatic m_step(input int i);
    logic [31:0] r;
    bit sa [4];
    int np0;
    bit sp;
    r = m_z[i][0] ^ m_z[i][1] ^ m_z[i][2] ^ m_z[i][3];
    m_load[i] = 0;
    m_ready[i] = 0;
    case (m_mode[i])
      0: if (gm) begin m_mode[i] = 1; m_k[i] = 0; end
      1: begin
        if (m_k[i] == 0) begin
          m_lm[i] = '0;
          m_lm[i][COLS/2] = 1'b1;
          m_pos[i][0] = COLS/2;
          m_act[i][0] = 1;
        end else begin
          if (m_k[i] == 1) begin
            for (int x = 0; x < COLS; x++) m_lm[i][x] = (x % 2 == 0);
          end else begin
            m_lm[i] = ~m_lm[i];
          end
          m_pos[i][0] = mv(m_pos[i][0], m_dir[i][0]);
        end
        for (int t = 1; t < 4; t++) m_act[i][t] = 0;
        m_load[i] = 1;
        if (m_k[i] == INIT - 1) begin m_ready[i] = 1; m_mode[i] = 2; end
        else m_k[i]++;
      end
      2: if (gm) m_mode[i] = 3;
      default: begin
        m_lm[i] = ~m_lm[i];
        np0 = mv(m_pos[i][0], m_dir[i][0]);
        m_pos[i][0] = np0;
        for (int t = 1; t < m_tracks[i]; t++) begin
          sa[t] = m_act[i][t];
          if (m_act[i][t]) begin
            if (m_life[i][t] == 0) begin
              m_act[i][t] = 0;
              if (i == 1) m_expires++;
            end else begin
              m_pos[i][t] = mv(m_pos[i][t], m_dir[i][t]);
              m_life[i][t]--;
            end
          end
        end
        sp = 0;
        if (!m_sp_prev[i] && int'(r[3:0]) < m_thr[i]) begin
          for (int t = 1; t < m_tracks[i]; t++) begin
            if (!sa[t] && !sp) begin
              sp = 1;
              m_act[i][t] = 1;
              m_pos[i][t] = np0;
              m_life[i][t] = int'(r[7:4]);
              if (i == 1) m_spawns++;
            end
          end
        end
        m_sp_prev[i] = sp;
        m_load[i] = 1;
        m_mode[i] = 2;
      end
    endcase
    m_busy[i] = (m_mode[i] == 1) || (m_mode[i] == 3);
    for (int t = 0; t < 4; t++) m_dir[i][t] = ^r[8*t +: 8];
    for (int j = 0; j < 4; j++) m_z[i][j] = tstep(m_z[i][j], j);
`ifdef LAYER_GEN_SEED_LOAD_EN
    if (seed_load) begin
      for (int j = 0; j < 4; j++) m_z[i][j] = seed_in;
      for (int t = 1; t < 4; t++) m_act[i][t] = 0;
      m_sp_prev[i] = 0;
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < NI; i++) m_reset(i);
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < NI; i++) begin
        if (rst) m_reset(i);
        else     m_step(i);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [0:COLS-1] c_lm, c_bt;
  logic c_ld, c_rd, c_by;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < NI; i++) begin
          if (i == 0) begin c_lm = lm_a; c_bt = bt_a; c_ld = ld_a; c_rd = rd_a; c_by = by_a; end
          else        begin c_lm = lm_b; c_bt = bt_b; c_ld = ld_b; c_rd = rd_b; c_by = by_b; end
          check($sformatf("model_layer_map[%0d]", i), 32'(c_lm), 32'(m_lm[i]));
          check($sformatf("model_block_type[%0d]", i), 32'(c_bt), 32'(exp_bt(i)));
          check($sformatf("model_load_layer[%0d]", i), 32'(c_ld), 32'(m_load[i]));
          check($sformatf("model_map_ready[%0d]", i), 32'(c_rd), 32'(m_ready[i]));
          check($sformatf("model_busy[%0d]", i), 32'(c_by), 32'(m_busy[i]));
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  logic [0:COLS-1] init_pat [4];
  logic [0:COLS-1] center_pat;
  int cnt, last, gap_bad;
`ifdef LAYER_GEN_SEED_LOAD_EN
  logic [0:COLS-1] s_lm [2][64];
  logic [0:COLS-1] s_bt [2][64];
`endif

  initial begin
    init_pat[0] = 7'b0001000;
    init_pat[1] = 7'b1010101;
    init_pat[2] = 7'b0101010;
    init_pat[3] = 7'b1010101;
    center_pat  = 7'b0001000;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_layer_map", 32'(lm_a), 32'h0);
    check("rst_block_type", 32'(bt_a), 32'h0);
    check("rst_load_layer", 32'(ld_a), 32'h0);
    check("rst_map_ready", 32'(rd_a), 32'h0);
    check("rst_busy", 32'(by_a), 32'h0);

    // Start-up sequence
    #1 gm = 1'b1;
    @(negedge clk); #1 gm = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check($sformatf("init_load[%0d]", n), 32'(ld_a), 32'h1);
      check($sformatf("init_layer[%0d]", n), 32'(lm_a), 32'(init_pat[n]));
      check($sformatf("init_ready[%0d]", n), 32'(rd_a), 32'(n == 3));
      check($sformatf("init_busy[%0d]", n), 32'(by_a), 32'(n < 3));
      if (n == 0) check("init_block_type0", 32'(bt_a), 32'(center_pat));
    end
    @(negedge clk);
    check("init_done_load", 32'(ld_a), 32'h0);

    // Reset mid start-up
    #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk); #1 gm = 1'b1;
    @(negedge clk); #1 gm = 1'b0;
    @(negedge clk);
    check("midrst_k0", 32'(lm_a), 32'(init_pat[0]));
    @(negedge clk);
    check("midrst_k1", 32'(lm_a), 32'(init_pat[1]));
    @(posedge clk); #1 rst = 1'b1; #1;
    check("async_rst_layer_map", 32'(lm_a), 32'h0);
    check("async_rst_block_type", 32'(bt_a), 32'h0);
    check("async_rst_load", 32'(ld_a), 32'h0);
    check("async_rst_busy", 32'(by_a), 32'h0);
    check("async_rst_block_type_b", 32'(bt_b), 32'h0);
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk); #1 gm = 1'b1;
    @(negedge clk); #1 gm = 1'b0;
    @(negedge clk);
    check("restart_k0", 32'(lm_a), 32'(init_pat[0]));
    check("restart_k0_load", 32'(ld_a), 32'h1);
    repeat (3) @(negedge clk);
    check("restart_k3", 32'(lm_a), 32'(init_pat[3]));
    check("restart_ready", 32'(rd_a), 32'h1);

    // Request held high for 200 cycles
    @(negedge clk); #1 gm = 1'b1;
    cnt = 0; last = -1; gap_bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ld_a) begin
        if (last >= 0 && c - last != 2) gap_bad++;
        last = c;
        cnt++;
      end
    end
    #1 gm = 1'b0;
    check("hold_strobes", 32'(cnt), 32'd100);
    check("hold_spacing", 32'(gap_bad), 32'd0);

    // Long run: 10,000 layers
    @(negedge clk); #1 gm = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (ld_a) cnt++;
    end
    #1 gm = 1'b0;
    check("long_run_layers", 32'(cnt), 32'd10000);

    // Random requests with occasional asynchronous reset pulses
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1 gm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 799) == 0) begin
        rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    @(negedge clk); #1 gm = 1'b0;

    check("spawns_seen", 32'(m_spawns > 0), 32'h1);
    check("expiries_seen", 32'(m_expires > 0), 32'h1);

`ifdef LAYER_GEN_SEED_LOAD_EN
    for (int run = 0; run < 2; run++) begin
      @(negedge clk); #1 rst = 1'b1;
      @(negedge clk); #1 rst = 1'b0;
      @(negedge clk); #1 seed_load = 1'b1; seed_in = 32'h13579BDF;
      @(negedge clk); #1 seed_load = 1'b0; gm = 1'b1;
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        s_lm[run][c] = lm_b;
        s_bt[run][c] = bt_b;
      end
      #1 gm = 1'b0;
    end
    for (int c = 0; c < 64; c++) begin
      check($sformatf("seed_repeat_lm[%0d]", c), 32'(s_lm[1][c]), 32'(s_lm[0][c]));
      check($sformatf("seed_repeat_bt[%0d]", c), 32'(s_bt[1][c]), 32'(s_bt[0][c]));
    end
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
